// File: rtl/pulse_gen_pkg.sv
// Shared definitions for pulse_gen: state encodings, counter width and
// counter-load helper, imported by the RTL and the bench alike.
package pulse_gen_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HIGH    = 2'd1,
        ST_GAP     = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // The down-counter reaches zero on the last cycle of a phase, so it loads N-1.
    function automatic logic [CNT_W-1:0] load_val(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/pulse_gen_sat_counter.sv
// Saturating up-counter used to tally discarded pulse requests.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold at all-ones once reached.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_gen.sv
// Pulse generator: each accepted trig yields one HIGH_CYCLES-wide pulse followed
// by at least GAP_CYCLES low cycles; one extra request may wait in a pending slot.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    output logic             out,
    output logic             busy,
    output logic             pending,
    output logic [CNT_W-1:0] drop_cnt
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_q;
    logic             pending_d;
    logic             out_q;
    logic             out_d;
    logic             busy_q;
    logic             busy_d;
    logic             queue_win_s;
    logic             drop_inc_s;
    logic             final_gap_s;

    assign final_gap_s = (state_q == ST_GAP) && (cnt_q == CNT_ZERO);
    // Requests arriving while a pulse or a non-final gap cycle runs go to the pending slot.
    assign queue_win_s = (state_q == ST_HIGH) || ((state_q == ST_GAP) && !final_gap_s);

    // Next-state, counter and pending-slot logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        drop_inc_s = 1'b0;

        if (queue_win_s && trig) begin
            if (pending_q) begin
                drop_inc_s = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            drop_inc_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_HIGH;
                    cnt_d   = load_val(HIGH_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_GAP;
                    cnt_d   = load_val(GAP_CYCLES);
                end else begin
                    state_d = ST_HIGH;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q != CNT_ZERO) begin
                    state_d = ST_GAP;
                    cnt_d   = cnt_q - CNT_ONE;
                end else if (pending_q || trig) begin
                    // A simultaneous trig takes over the slot just served.
                    state_d   = ST_HIGH;
                    cnt_d     = load_val(HIGH_CYCLES);
                    pending_d = pending_q && trig;
                end else begin
                    state_d   = ST_IDLE;
                    cnt_d     = CNT_ZERO;
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                pending_d = 1'b0;
            end
        endcase

        out_d  = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    // State machine and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            pending_q <= 1'b0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc_s),
        .count (drop_cnt)
    );

    assign out     = out_q;
    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: directed scenarios plus a position-based reference model
// compared against the outputs on every falling edge.
module tb_pulse_gen;
    import pulse_gen_pkg::*;

    localparam int H = 4;
    localparam int G = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             trig;
    logic             out;
    logic             busy;
    logic             pending;
    logic [CNT_W-1:0] drop_cnt;

    int  total = 0;
    int  bad   = 0;
    bit  chk_en = 1'b0;

    // Reference model: pos = cycles into the current pulse+gap window, -1 when idle.
    int  m_pos = -1;
    bit  m_pend = 1'b0;
    int  m_drops = 0;
    int  seg_reqs = 0;
    int  seg_drops = 0;
    int  seg_edges = 0;
    bit  prev_out = 1'b0;

    always #5 clk = ~clk;

    pulse_gen #(.HIGH_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .trig(trig), .out(out),
        .busy(busy), .pending(pending), .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_pend = 1'b0; m_drops = 0;
        seg_reqs = 0; seg_drops = 0; seg_edges = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            if (trig) seg_reqs++;
            if (m_pos < 0) begin
                if (trig) m_pos = 0;
            end else if (m_pos == H + G - 1) begin
                if (m_pend || trig) begin
                    m_pos  = 0;
                    m_pend = m_pend && trig;
                end else begin
                    m_pos = -1;
                end
            end else begin
                if (trig) begin
                    if (m_pend) begin
                        m_drops++; seg_drops++;
                    end else begin
                        m_pend = 1'b1;
                    end
                end
                m_pos++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy; i++) tick();
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic edge_check(input string name);
        check(name, seg_edges, seg_reqs - seg_drops);
    endtask

    // Per-cycle comparison against the model and rising-edge counting on out.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                check("cmp_out", int'(out), int'(m_pos >= 0 && m_pos < H));
                check("cmp_busy", int'(busy), int'(m_pos >= 0));
                check("cmp_pending", int'(pending), int'(m_pend));
                check("cmp_drop_cnt", int'(drop_cnt), (m_drops > 255) ? 255 : m_drops);
                if (out && !prev_out) seg_edges++;
                prev_out = out;
            end else begin
                prev_out = 1'b0;
            end
        end
    end

    initial begin
        int e0;
        rst = 1'b1; trig = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_out", int'(out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_drop", int'(drop_cnt), 0);
        #2; rst = 1'b0; chk_en = 1'b1;
        tick();

        // Single request: high 4 cycles, low 2, then idle.
        trig = 1'b1; tick(); trig = 1'b0;
        for (int i = 0; i < H; i++) begin
            check("single_high", int'(out), 1);
            tick();
        end
        for (int i = 0; i < G; i++) begin
            check("single_gap_out", int'(out), 0);
            check("single_gap_busy", int'(busy), 1);
            tick();
        end
        check("single_idle_busy", int'(busy), 0);
        check("single_drop", int'(drop_cnt), 0);
        edge_check("edges_single");

        // Back-to-back: trig at N and N+2.
        e0 = seg_edges;
        trig = 1'b1; tick(); trig = 1'b0; tick();
        trig = 1'b1; tick(); trig = 1'b0;
        check("b2b_pending", int'(pending), 1);
        repeat (3) tick();
        check("b2b_final_gap_out", int'(out), 0);
        tick();
        check("b2b_second_high", int'(out), 1);
        check("b2b_pending_cleared", int'(pending), 0);
        repeat (3) tick();
        check("b2b_second_last_high", int'(out), 1);
        tick();
        check("b2b_second_end", int'(out), 0);
        wait_idle(20);
        check("b2b_edges", seg_edges - e0, 2);
        edge_check("edges_b2b");

        // Overflow: trig held 10 cycles from idle.
        e0 = seg_edges;
        trig = 1'b1; repeat (10) tick(); trig = 1'b0;
        check("ovf_pending", int'(pending), 1);
        check("ovf_drop", int'(drop_cnt), 7);
        wait_idle(40);
        check("ovf_edges", seg_edges - e0, 3);
        edge_check("edges_ovf");

        // Final-gap simultaneity: pending=1 and trig=1 on the last gap cycle.
        e0 = seg_edges;
        trig = 1'b1; tick(); tick(); trig = 1'b0;
        repeat (4) tick();
        check("fg_pending_before", int'(pending), 1);
        check("fg_out_before", int'(out), 0);
        trig = 1'b1; tick(); trig = 1'b0;
        check("fg_high", int'(out), 1);
        check("fg_pending_kept", int'(pending), 1);
        check("fg_drop_same", int'(drop_cnt), 7);
        wait_idle(40);
        check("fg_edges", seg_edges - e0, 3);
        edge_check("edges_fg");

        // Saturation: hold trig long enough for well over 255 drops.
        trig = 1'b1; repeat (320) tick(); trig = 1'b0;
        check("sat_drop", int'(drop_cnt), 255);
        wait_idle(40);
        check("sat_drop_hold", int'(drop_cnt), 255);
        edge_check("edges_sat");

        // Asynchronous reset mid-HIGH with a pending request.
        trig = 1'b1; tick(); tick(); trig = 1'b0;
        check("rst_pre_out", int'(out), 1);
        check("rst_pre_pending", int'(pending), 1);
        #2; rst = 1'b1; trig = 1'b1; model_reset();
        #1;
        check("rst_async_out", int'(out), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_pending", int'(pending), 0);
        check("rst_async_drop", int'(drop_cnt), 0);
        repeat (2) tick();
        check("rst_trig_ignored", int'(busy), 0);
        #2; rst = 1'b0; trig = 1'b0;
        repeat (6) tick();
        check("rst_no_pulse_out", int'(out), 0);
        check("rst_no_pulse_busy", int'(busy), 0);

        // First request honoured on the first edge after release.
        #2; rst = 1'b1; model_reset(); trig = 1'b1;
        tick();
        #2; rst = 1'b0;
        tick(); trig = 1'b0;
        check("rst_first_req", int'(out), 1);
        wait_idle(20);
        edge_check("edges_after_rst");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
